// File: rtl/allocate_frcr_pkg.sv
// Shared types and reset constants for the FRCR compare/interrupt block.
`timescale 1ns/1ps
package allocate_frcr_pkg;

   localparam int CNT_WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_PENDING,
      ST_PEND_ARMED
   } state_t;

   localparam state_t      RST_STATE         = ST_IDLE;
   localparam logic [63:0] RST_CMP_VALUE     = 64'd0;
   localparam logic [63:0] RST_PERIOD        = 64'd0;
   localparam logic        RST_PERIODIC      = 1'b0;
   localparam logic        RST_OVERRUN       = 1'b0;
   localparam logic [63:0] RST_MATCH_COUNTER = 64'd0;

endpackage

// File: rtl/allocate_frcr_cmp_match.sv
// Wrap-safe "counter has reached compare" detector: the sign bit of
// (counter - compare) stays clear once the counter is at or past compare.
`timescale 1ns/1ps
module allocate_frcr_cmp_match
   import allocate_frcr_pkg::*;
#(
   parameter int P_CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
   input  logic [P_CNT_WIDTH-1:0] counter,
   input  logic [P_CNT_WIDTH-1:0] compare,
   input  logic                   enable,
   output logic                   match
);

   logic [P_CNT_WIDTH-1:0] diff;

   assign diff  = counter - compare;
   assign match = enable & ~diff[P_CNT_WIDTH-1];

endmodule

// File: rtl/allocate_frcr_compare_irq.sv
// Compare-match interrupt on a free-running counter, one-shot or periodic.
// Define ALLOCATE_FRCR_CMP_SNAPSHOT_EN to capture the counter on each match.
`timescale 1ns/1ps
module allocate_frcr_compare_irq
   import allocate_frcr_pkg::*;
#(
   parameter int P_CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
   input  logic                   iCLOCK,
   input  logic                   iRESET_SYNC,
   input  logic [P_CNT_WIDTH-1:0] iCOUNTER,
   input  logic                   iCMP_WR_ENA,
   input  logic [P_CNT_WIDTH-1:0] iCMP_VALUE,
   input  logic                   iCFG_WR_ENA,
   input  logic                   iCFG_ENA,
   input  logic                   iCFG_PERIODIC,
   input  logic [P_CNT_WIDTH-1:0] iCFG_PERIOD,
   output logic                   oIRQ_VALID,
   input  logic                   iIRQ_ACK,
   output logic                   oIRQ_OVERRUN,
   output logic [P_CNT_WIDTH-1:0] oCMP_VALUE,
   output logic [P_CNT_WIDTH-1:0] oMATCH_COUNTER
);

   localparam logic [P_CNT_WIDTH-1:0] CMP_RST    = P_CNT_WIDTH'(RST_CMP_VALUE);
   localparam logic [P_CNT_WIDTH-1:0] PERIOD_RST = P_CNT_WIDTH'(RST_PERIOD);
   localparam logic [P_CNT_WIDTH-1:0] MCNT_RST   = P_CNT_WIDTH'(RST_MATCH_COUNTER);

   state_t                 state_q, state_d;
   logic [P_CNT_WIDTH-1:0] cmp_q, cmp_d;
   logic [P_CNT_WIDTH-1:0] period_q, period_d;
   logic                   periodic_q, periodic_d;
   logic                   overrun_q, overrun_d;

   logic irq_valid;
   logic armed;
   logic ack;
   logic cfg_disable;
   logic periodic_mode;
   logic match_ena;
   logic match;

   assign irq_valid     = (state_q == ST_PENDING) || (state_q == ST_PEND_ARMED);
   assign armed         = (state_q == ST_ARMED)   || (state_q == ST_PEND_ARMED);
   assign ack           = iIRQ_ACK && irq_valid;
   assign cfg_disable   = iCFG_WR_ENA && !iCFG_ENA;
   assign periodic_mode = periodic_q && (period_q != '0);
   // A compare write or a disable in the same cycle masks any match on stale state.
   assign match_ena     = armed && !iCMP_WR_ENA && !cfg_disable;

   allocate_frcr_cmp_match #(
      .P_CNT_WIDTH(P_CNT_WIDTH)
   ) u_cmp_match (
      .counter (iCOUNTER),
      .compare (cmp_q),
      .enable  (match_ena),
      .match   (match)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      cmp_d      = cmp_q;
      period_d   = period_q;
      periodic_d = periodic_q;
      overrun_d  = overrun_q;

      unique case (state_q)
         ST_IDLE:       ;
         ST_ARMED:      if (match) state_d = periodic_mode ? ST_PEND_ARMED : ST_PENDING;
         ST_PENDING:    if (ack)   state_d = ST_IDLE;
         ST_PEND_ARMED: begin
            if (match) begin
               if (!periodic_mode) state_d = ST_PENDING;
            end else if (ack) begin
               state_d = ST_ARMED;
            end
         end
         default:       state_d = ST_IDLE;
      endcase

      if (ack)                    overrun_d = 1'b0;
      else if (match && irq_valid) overrun_d = 1'b1;

      if (iCMP_WR_ENA)                 cmp_d = iCMP_VALUE;
      else if (match && periodic_mode) cmp_d = cmp_q + period_q;

      if (iCFG_WR_ENA) begin
         periodic_d = iCFG_PERIODIC;
         period_d   = iCFG_PERIOD;
         if (!iCFG_ENA) begin
            state_d   = ST_IDLE;
            overrun_d = 1'b0;
         end else if (state_q == ST_IDLE) begin
            state_d = ST_ARMED;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_q    <= RST_STATE;
         cmp_q      <= CMP_RST;
         period_q   <= PERIOD_RST;
         periodic_q <= RST_PERIODIC;
         overrun_q  <= RST_OVERRUN;
      end else begin
         state_q    <= state_d;
         cmp_q      <= cmp_d;
         period_q   <= period_d;
         periodic_q <= periodic_d;
         overrun_q  <= overrun_d;
      end
   end

`ifdef ALLOCATE_FRCR_CMP_SNAPSHOT_EN
   logic [P_CNT_WIDTH-1:0] match_counter_q;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC)  match_counter_q <= MCNT_RST;
      else if (match)   match_counter_q <= iCOUNTER;
   end

   assign oMATCH_COUNTER = match_counter_q;
`else
   assign oMATCH_COUNTER = MCNT_RST;
`endif

   assign oIRQ_VALID   = irq_valid;
   assign oIRQ_OVERRUN = overrun_q;
   assign oCMP_VALUE   = cmp_q;

endmodule

// File: tb/tb_allocate_frcr_compare_irq.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a monitor
// on the falling edge pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_allocate_frcr_compare_irq;

   typedef enum int {K_VALID, K_OVR, K_CMP, K_MCNT} kind_e;

   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [63:0] val;
      string       name;
   } exp_t;

`ifdef ALLOCATE_FRCR_CMP_SNAPSHOT_EN
   localparam bit SNAP = 1'b1;
`else
   localparam bit SNAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] counter;
   logic        cmp_wr;
   logic [63:0] cmp_val;
   logic        cfg_wr;
   logic        cfg_ena;
   logic        cfg_per;
   logic [63:0] cfg_period;
   logic        irq_valid;
   logic        ack;
   logic        ovr;
   logic [63:0] cmp_out;
   logic [63:0] mcnt;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];

   allocate_frcr_compare_irq #(.P_CNT_WIDTH(64)) dut (
      .iCLOCK         (clk),
      .iRESET_SYNC    (rst),
      .iCOUNTER       (counter),
      .iCMP_WR_ENA    (cmp_wr),
      .iCMP_VALUE     (cmp_val),
      .iCFG_WR_ENA    (cfg_wr),
      .iCFG_ENA       (cfg_ena),
      .iCFG_PERIODIC  (cfg_per),
      .iCFG_PERIOD    (cfg_period),
      .oIRQ_VALID     (irq_valid),
      .iIRQ_ACK       (ack),
      .oIRQ_OVERRUN   (ovr),
      .oCMP_VALUE     (cmp_out),
      .oMATCH_COUNTER (mcnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expectation for the outputs visible k cycles after the current one.
   task automatic expect_at(input int k, input kind_e kind, input logic [63:0] val,
                            input string name);
      exp_t e;
      int   idx;
      e.cyc  = cyc + k;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      idx    = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > e.cyc) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cmp_wr = 1'b0;
      cfg_wr = 1'b0;
      ack    = 1'b0;
   endtask

   task automatic write_cmp(input logic [63:0] v);
      cmp_wr  = 1'b1;
      cmp_val = v;
   endtask

   task automatic write_cfg(input logic ena, input logic per, input logic [63:0] period);
      cfg_wr     = 1'b1;
      cfg_ena    = ena;
      cfg_per    = per;
      cfg_period = period;
   endtask

   logic [63:0] act;
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin : pop_one
         exp_t e;
         e = sb.pop_front();
         case (e.kind)
            K_VALID: act = {63'd0, irq_valid};
            K_OVR:   act = {63'd0, ovr};
            K_CMP:   act = cmp_out;
            default: act = mcnt;
         endcase
         n_checks++;
         if (e.cyc != cyc)
            $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
         else if (act === e.val)
            n_pass++;
         else
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.val, cyc);
      end
   end

   initial begin
      logic [63:0] c;
      rst = 1'b1; counter = '0; cmp_wr = 1'b0; cmp_val = '0; cfg_wr = 1'b0;
      cfg_ena = 1'b0; cfg_per = 1'b0; cfg_period = '0; ack = 1'b0;
      tick();
      tick();
      expect_at(0, K_VALID, 64'd0, "rst_valid");
      expect_at(0, K_OVR,   64'd0, "rst_ovr");
      expect_at(0, K_CMP,   64'd0, "rst_cmp");
      expect_at(0, K_MCNT,  64'd0, "rst_mcnt");
      rst = 1'b0;

      // One-shot at 100
      counter = 64'd95;
      write_cmp(64'd100);
      write_cfg(1'b1, 1'b0, 64'd0);
      tick();
      for (int v = 96; v <= 100; v++) begin
         counter = 64'(v);
         if (v == 99) expect_at(1, K_VALID, 64'd0, "os_early");
         if (v == 100) begin
            expect_at(1, K_VALID, 64'd1, "os_fire");
            expect_at(1, K_MCNT, SNAP ? 64'd100 : 64'd0, "os_snapshot");
         end
         tick();
      end
      counter = 64'd101;
      expect_at(0, K_VALID, 64'd1, "os_hold");
      expect_at(0, K_CMP, 64'd100, "os_cmp");
      ack = 1'b1;
      tick();
      counter = 64'd200;
      expect_at(0, K_VALID, 64'd0, "os_acked");
      expect_at(1, K_VALID, 64'd0, "os_no_refire1");
      tick();
      expect_at(1, K_VALID, 64'd0, "os_no_refire2");
      tick();

      // Periodic: compare 10, period 10
      counter = 64'd0;
      write_cmp(64'd10);
      write_cfg(1'b1, 1'b1, 64'd10);
      tick();
      for (int v = 1; v <= 35; v++) begin
         counter = 64'(v);
         if (v == 10 || v == 20 || v == 30) begin
            expect_at(1, K_VALID, 64'd1, "per_fire");
            expect_at(1, K_CMP, 64'(v + 10), "per_reload");
         end
         if (v == 9 || v == 15 || v == 25) expect_at(1, K_VALID, 64'd0, "per_quiet");
         if (v == 11 || v == 21 || v == 31) ack = 1'b1;
         tick();
      end

      // Overrun and simultaneous ack+match, period 4 from 100
      counter = 64'd96;
      write_cmp(64'd100);
      write_cfg(1'b1, 1'b1, 64'd4);
      tick();
      for (int v = 97; v <= 117; v++) begin
         counter = 64'(v);
         case (v)
            100: begin
               expect_at(1, K_VALID, 64'd1, "ovr_fire");
               expect_at(1, K_OVR, 64'd0, "ovr_clear_first");
               expect_at(1, K_CMP, 64'd104, "ovr_cmp104");
            end
            104: begin
               expect_at(1, K_OVR, 64'd1, "ovr_set");
               expect_at(1, K_CMP, 64'd108, "ovr_cmp108");
            end
            107: begin
               ack = 1'b1;
               expect_at(1, K_VALID, 64'd0, "ovr_ack_valid");
               expect_at(1, K_OVR, 64'd0, "ovr_ack_ovr");
            end
            108: expect_at(1, K_VALID, 64'd1, "ovr_refire");
            112: expect_at(1, K_OVR, 64'd1, "ovr_set2");
            116: begin
               ack = 1'b1;
               expect_at(1, K_VALID, 64'd1, "simul_valid");
               expect_at(1, K_OVR, 64'd0, "simul_ovr");
               expect_at(1, K_CMP, 64'd120, "simul_cmp");
            end
            117: begin
               ack = 1'b1;
               expect_at(1, K_VALID, 64'd0, "simul_ack2");
            end
            default: ;
         endcase
         tick();
      end
      counter = 64'd118;
      write_cfg(1'b0, 1'b0, 64'd0);
      tick();

      // Wrap-around: compare 2^64-2, period 4
      c = 64'hFFFF_FFFF_FFFF_FFFC;
      counter = c;
      write_cmp(64'hFFFF_FFFF_FFFF_FFFE);
      write_cfg(1'b1, 1'b1, 64'd4);
      tick();
      for (int i = 1; i <= 7; i++) begin
         counter = c + 64'(i);
         case (i)
            1: expect_at(1, K_VALID, 64'd0, "wrap_before");
            2: begin
               expect_at(1, K_VALID, 64'd1, "wrap_fire1");
               expect_at(1, K_CMP, 64'd2, "wrap_cmp2");
            end
            3: begin
               ack = 1'b1;
               expect_at(1, K_VALID, 64'd0, "wrap_ack1");
            end
            4: expect_at(1, K_VALID, 64'd0, "wrap_no_at0");
            5: expect_at(1, K_VALID, 64'd0, "wrap_no_at1");
            6: begin
               expect_at(1, K_VALID, 64'd1, "wrap_fire2");
               expect_at(1, K_CMP, 64'd6, "wrap_cmp6");
               expect_at(1, K_MCNT, SNAP ? 64'd2 : 64'd0, "wrap_snapshot");
            end
            default: ack = 1'b1;
         endcase
         tick();
      end

      // Compare write beats a match in the same cycle; one-shot from here
      counter = 64'd6;
      write_cmp(64'd50);
      write_cfg(1'b1, 1'b0, 64'd0);
      expect_at(1, K_VALID, 64'd0, "wr_wins_valid");
      expect_at(1, K_CMP, 64'd50, "wr_wins_cmp");
      tick();
      counter = 64'd7;
      expect_at(1, K_VALID, 64'd0, "wr_quiet");
      tick();
      counter = 64'd50;
      expect_at(1, K_VALID, 64'd1, "wr_fire");
      expect_at(1, K_CMP, 64'd50, "wr_no_reload");
      expect_at(1, K_MCNT, SNAP ? 64'd50 : 64'd0, "wr_snapshot");
      tick();

      // Reset while pending wins over a simultaneous write
      counter = 64'd51;
      expect_at(0, K_VALID, 64'd1, "pend_before_rst");
      rst = 1'b1;
      write_cmp(64'd77);
      write_cfg(1'b1, 1'b1, 64'd3);
      expect_at(1, K_VALID, 64'd0, "rst_pend_valid");
      expect_at(1, K_OVR, 64'd0, "rst_pend_ovr");
      expect_at(1, K_CMP, 64'd0, "rst_pend_cmp");
      expect_at(1, K_MCNT, 64'd0, "rst_pend_mcnt");
      tick();
      rst = 1'b0;
      counter = 64'd60;
      expect_at(1, K_VALID, 64'd0, "idle_no_match");
      tick();
      tick();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
         n_checks += sb.size();
      end
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/allocate_frcr_compare_irq.md
ALLOCATE_FRCR_COMPARE_IRQ -- requirements
Module: allocate_frcr_compare_irq

Interface
REQ-001 SHALL have parameter: P_CNT_WIDTH, 64, width of counter/compare/period datapath.
REQ-002 SHALL have port: iCLOCK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: iRESET_SYNC  in  1  synchronous active-high reset.
REQ-004 SHALL have port: iCOUNTER  in  64  free-running FRCR counter value being monitored.
REQ-005 SHALL have ports: iCMP_WR_ENA in 1 and iCMP_VALUE in 64; compare-register write strobe and data.
REQ-006 SHALL have ports: iCFG_WR_ENA in 1, iCFG_ENA in 1, iCFG_PERIODIC in 1, iCFG_PERIOD in 64; config write strobe, enable, mode, reload period.
REQ-007 SHALL have ports: oIRQ_VALID out 1, iIRQ_ACK in 1; level interrupt request and acknowledge.
REQ-008 SHALL have ports: oIRQ_OVERRUN out 1 (sticky missed match), oCMP_VALUE out 64 (current compare), oMATCH_COUNTER out 64 (match snapshot).

Function
REQ-009 SHALL implement states IDLE, ARMED, PENDING, PEND_ARMED (pending IRQ while periodic re-armed).
REQ-010 SHALL detect a match when armed and bit 63 of (iCOUNTER - compare) mod 2^64 is 0, i.e. wrap-safe signed "counter reached compare".
REQ-011 SHALL assert oIRQ_VALID on the cycle after a match is detected (one-cycle latency).
REQ-012 SHALL hold oIRQ_VALID high until sampled iIRQ_ACK; ack while oIRQ_VALID low is ignored.
REQ-013 SHALL, in one-shot mode (iCFG_PERIODIC=0 or period=0), go ARMED->PENDING on match and PENDING->IDLE on ack.
REQ-014 SHALL, in periodic mode with period!=0, on match update compare <= compare + period (mod 2^64) and stay armed (ARMED->PEND_ARMED, PEND_ARMED->ARMED on ack).
REQ-015 SHALL set oIRQ_OVERRUN when a match occurs while oIRQ_VALID is high; it clears only on ack.
REQ-016 SHALL, on simultaneous ack and new match, keep oIRQ_VALID high, clear oIRQ_OVERRUN, not set overrun.
REQ-017 SHALL give iCMP_WR_ENA priority over match reload in the same cycle; match evaluation suppressed that cycle.
REQ-018 SHALL, on iCFG_WR_ENA with iCFG_ENA=0, go IDLE, drop oIRQ_VALID and oIRQ_OVERRUN; with iCFG_ENA=1 from IDLE, go ARMED next cycle.
REQ-019 SHALL not generate a match in IDLE regardless of iCOUNTER.
REQ-020 SHALL drive oCMP_VALUE from the compare register at all times.

Reset
REQ-021 SHALL, on iRESET_SYNC, set state IDLE, compare 0, period 0, mode one-shot, oIRQ_VALID 0, oIRQ_OVERRUN 0, oMATCH_COUNTER 0.
REQ-022 SHALL give iRESET_SYNC priority over every write, ack and match, including mid-PENDING.

Configuration
REQ-023 SHALL support macro ALLOCATE_FRCR_CMP_SNAPSHOT_EN.
REQ-024 SHALL, when defined, latch iCOUNTER into oMATCH_COUNTER on each match cycle (held until next match/reset).
REQ-025 SHALL, when undefined, tie oMATCH_COUNTER to 0 with no snapshot register.

Structure
REQ-026 SHALL place state enum, P_CNT_WIDTH default and reset constants in package allocate_frcr_pkg.
REQ-027 SHALL implement the wrap-safe subtract comparator as sub-module allocate_frcr_cmp_match.

Verification
REQ-028 SHALL test one-shot: cmp=100, ENA=1, counter 95->100 -> oIRQ_VALID=1 at counter 101 cycle; ack -> 0, state IDLE, no refire at 200.
REQ-029 SHALL test periodic: cmp=10, period=10 -> IRQ at 10,20,30; oCMP_VALUE 20,30,40 after each match.
REQ-030 SHALL test overrun: periodic period=4, no ack across two matches -> oIRQ_OVERRUN=1; ack -> both clear.
REQ-031 SHALL test wrap: cmp=0xFFFF_FFFF_FFFF_FFFE, period=4, counter wraps -> next compare 0x2, match at counter 0x2 only.
REQ-032 SHALL test simultaneous cmp write and match, and iRESET_SYNC while PENDING -> write wins / all outputs reset values next cycle.
REQ-033 SHALL test with and without ALLOCATE_FRCR_CMP_SNAPSHOT_EN: match at 100 -> oMATCH_COUNTER=100 resp. 0.
